axis_ddr_burst_writer: RTL and testbench
========================================

Name: axis_ddr_burst_writer

Overview:
- Write-path front end for the XDMA/DDR subsystem. Sits directly upstream of the DDR AXI4 slave port inside the XDMA/DDR wrapper, in the user_clk domain.
- Collects an AXI-Stream sample stream into a local buffer. Emits fixed-address-slot AXI4 INCR write bursts into a circular DDR region, which XDMA later reads back to host.
- Provides sticky error and progress status for host polling.

Parameters:
- DATA_W, 64, stream and AXI data width in bits (power of 2, 32..512)
- ADDR_W, 32, AXI address width
- BURST_LEN, 16, max beats per burst (2..256, power of 2)
- BASE_ADDR, 32'h0000_0000, region start, aligned to BURST_LEN*DATA_W/8
- REGION_BYTES, 32'h0010_0000, region size, multiple of the burst slot size

Ports:
- user_clk  in  1  sole clock
- user_rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_W  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  end of packet; closes the current burst early
- m_axi_awaddr  out  ADDR_W  burst start address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant log2(DATA_W/8)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  DATA_W  write data
- m_axi_wstrb  out  DATA_W/8  all ones
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  response ready
- wr_err  out  1  sticky; set on any bresp != 2'b00
- burst_cnt  out  32  completed bursts, wraps at 2^32

Behaviour:
- Reset (async assert, sync release):
  - state=FILL, buffer flushed, fill count 0.
  - awvalid, wvalid, bready, wlast = 0; awaddr=BASE_ADDR; awlen=0.
  - wr_err=0, burst_cnt=0, s_axis_tready=0 during reset.
- Reset mid-burst abandons the transaction. The DDR slave shares user_rst_n, so no partial-burst recovery is needed.
- States:
  - FILL:
    - s_axis_tready=1 while count<BURST_LEN.
    - Each tvalid&tready pushes tdata into the buffer and increments count.
    - Go to AW the cycle after count reaches BURST_LEN, or after a beat with tlast=1 is accepted.
    - tlast on the first beat gives a 1-beat burst.
    - No bursts are issued with count 0.
  - AW:
    - awvalid=1, awaddr=current slot, awlen=count-1, tready=0.
    - awaddr and awlen are held stable until awready.
    - On awvalid&awready go to W.
  - W:
    - wvalid=1 while buffer non-empty; wdata = buffer head (FWFT).
    - wlast=1 exactly on the final beat (remaining==1).
    - Pop on wvalid&wready. After the wlast handshake go to B.
    - wvalid may stay low only if the buffer is empty, which cannot occur mid-burst.
  - B:
    - bready=1. On bvalid:
      - set wr_err if bresp!=0;
      - burst_cnt+=1;
      - slot address += BURST_LEN*DATA_W/8, regardless of the short-burst count;
      - if the new address >= BASE_ADDR+REGION_BYTES, wrap to BASE_ADDR;
      - go to FILL with count=0.
- Latency: first AW asserts 1 cycle after the BURST_LEN-th (or tlast) beat is accepted. The first W beat follows the AW handshake by 1 cycle.
- Bursts never cross 4 KB, because slots are slot-aligned and the slot size is at most 4096 bytes. A parameter check fails elaboration if BURST_LEN*DATA_W/8 > 4096.
- One outstanding burst only; AW always precedes W.
- Back-pressure: s_axis_tready=0 in AW/W/B. Stream data must not be dropped.
- bvalid arriving while not in state B is ignored (bready=0).
- wr_err is cleared only by reset.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - The state enum type: FILL, AW, W, B.
  - A clog2-based awsize helper function.
- One sub-module: sync_fifo_fwft.
  - Depth BURST_LEN, width DATA_W, single clock, async active-low reset.
  - Provides push, pop, empty, full, count.

Test Plan:
- Two packets, back-to-back, 32 beats each with data = incrementing beat index, awready/wready always 1 (DATA_W=64, BURST_LEN=16) -> four AW at 0x000, 0x080, 0x100, 0x180, all awlen=15; wlast on beats 15 and 31 of each packet; burst_cnt=4.
- A 5-beat packet with tlast on beat 5 -> one AW with awlen=4; exactly 5 W beats, wlast on the 5th; next AW at slot+0x80.
- Random awready/wready/bvalid stalls (0..7 cycles) over 1000 beats -> scoreboard matches all data in order; AW/W signals stay stable while stalled; no tready during AW/W/B.
- REGION_BYTES=0x200, 5 full bursts -> addresses 0x000, 0x080, 0x100, 0x180, then wrap to 0x000.
- bresp=2'b10 on burst 2 -> wr_err=1 from the cycle after that B handshake; wr_err stays 1 and bursts continue.
- Assert user_rst_n=0 for 60 ns during state W of burst 3 -> all valids go low immediately; awaddr=BASE_ADDR; burst_cnt=0; after release, fresh bursts resume from BASE_ADDR.

Source files
------------

// File: rtl/axis_ddr_burst_writer_pkg.sv
// Shared AXI constants, controller state type and size helper for the
// stream-to-DDR burst writer.
package axis_ddr_burst_writer_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

  // AXI AxSIZE encoding for a bus of data_w bits: log2 of the byte width.
  function automatic logic [2:0] awsize_f(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axis_ddr_burst_writer_fifo.sv
// First-word-fall-through synchronous FIFO that holds one burst of stream
// data; the head word is visible on pop_data whenever empty is low.
module sync_fifo_fwft #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: the storage array is deliberately not reset; validity is defined
  // only by the pointers and count, which lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axis_ddr_burst_writer.sv
// Collects an AXI-Stream into a one-burst buffer and writes it to a circular
// DDR region as slot-aligned AXI4 INCR bursts, one burst outstanding at a time.
module axis_ddr_burst_writer
  import axis_ddr_burst_writer_pkg::*;
#(
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       BURST_LEN    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h0000_0000,
  parameter logic [ADDR_W-1:0] REGION_BYTES = 'h0010_0000
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                wr_err,
  output logic [31:0]         burst_cnt
);

  localparam int unsigned       SLOT_BYTES = BURST_LEN * DATA_W / 8;
  localparam int                CNT_W      = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W:0]   SLOT_INC   = (ADDR_W + 1)'(SLOT_BYTES);
  localparam logic [ADDR_W:0]   REGION_END = {1'b0, BASE_ADDR} + {1'b0, REGION_BYTES};

  // Slot-aligned bursts can only cross a 4 KB boundary if a slot exceeds 4 KB.
  if (SLOT_BYTES > 4096) begin : g_slot_too_large
    $error("axis_ddr_burst_writer: BURST_LEN*DATA_W/8 exceeds 4096 bytes");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   slot_q, slot_d;
  logic [7:0]          awlen_q, awlen_d;
  logic                wr_err_q, wr_err_d;
  logic [31:0]         burst_cnt_q, burst_cnt_d;
  logic                run_q, run_d;

  logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [DATA_W-1:0]   fifo_head;
  logic [ADDR_W:0]     slot_inc;
  logic [ADDR_W-1:0]   slot_next;

  sync_fifo_fwft #(
    .DEPTH (BURST_LEN),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (user_clk),
    .rst_n     (user_rst_n),
    .push      (fifo_push),
    .push_data (s_axis_tdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

  // Every slot advances by a full slot, even after a short tlast burst.
  always_comb begin
    slot_inc  = {1'b0, slot_q} + SLOT_INC;
    slot_next = (slot_inc >= REGION_END) ? BASE_ADDR : slot_inc[ADDR_W-1:0];
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d       = state_q;
    slot_d        = slot_q;
    awlen_d       = awlen_q;
    wr_err_d      = wr_err_q;
    burst_cnt_d   = burst_cnt_q;
    run_d         = 1'b1;
    s_axis_tready = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_FILL: begin
        // run_q keeps tready low while reset is held and for one cycle after.
        s_axis_tready = run_q && !fifo_full;
        fifo_push     = s_axis_tvalid && s_axis_tready;
        if (fifo_push && (s_axis_tlast || fifo_cnt == CNT_W'(BURST_LEN - 1))) begin
          // fifo_cnt is the pre-push count, which is exactly beats-1.
          awlen_d = 8'(fifo_cnt);
          state_d = ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          state_d = ST_W;
        end
      end
      ST_W: begin
        m_axi_wvalid = !fifo_empty;
        m_axi_wlast  = m_axi_wvalid && (fifo_cnt == CNT_W'(1));
        fifo_pop     = m_axi_wvalid && m_axi_wready;
        if (fifo_pop && m_axi_wlast) begin
          state_d = ST_B;
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          wr_err_d    = wr_err_q || (m_axi_bresp != RESP_OKAY);
          burst_cnt_d = burst_cnt_q + 32'd1;
          slot_d      = slot_next;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= ST_FILL;
      slot_q      <= BASE_ADDR;
      awlen_q     <= 8'd0;
      wr_err_q    <= 1'b0;
      burst_cnt_q <= 32'd0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      awlen_q     <= awlen_d;
      wr_err_q    <= wr_err_d;
      burst_cnt_q <= burst_cnt_d;
      run_q       <= run_d;
    end
  end

  assign m_axi_awaddr  = slot_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = awsize_f(DATA_W);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_wdata   = fifo_head;
  assign m_axi_wstrb   = '1;
  assign wr_err        = wr_err_q;
  assign burst_cnt     = burst_cnt_q;

endmodule

// File: tb/tb_axis_ddr_burst_writer.sv
// Directed bench for axis_ddr_burst_writer: a reactive AXI slave records
// AW/W/B traffic while a linear stimulus sequence drives the stream side.
module tb_axis_ddr_burst_writer;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 32;
  localparam int BURST_LEN = 16;

  logic              user_clk;
  logic              user_rst_n;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [7:0]        m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic              wr_err;
  logic [31:0]       burst_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q  [$];
  logic [63:0] w_data_q  [$];
  logic        w_last_q  [$];
  int          b_count = 0;
  bit          stall   = 1'b0;
  bit          hold_w  = 1'b0;
  int          err_k   = -1;

  axis_ddr_burst_writer #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .BURST_LEN    (BURST_LEN),
    .BASE_ADDR    (32'h0000_0000),
    .REGION_BYTES (32'h0000_0200)
  ) dut (
    .user_clk      (user_clk),
    .user_rst_n    (user_rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .wr_err        (wr_err),
    .burst_cnt     (burst_cnt)
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [63:0] data, input logic last);
    int guard = 0;
    s_axis_tdata  = data;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (!s_axis_tready && guard < 2000) begin
      @(negedge user_clk);
      guard++;
    end
    if (guard >= 2000) check("tready_timeout", s_axis_tready, 1);
    @(negedge user_clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Returns at the negedge following the n-th B handshake.
  task automatic wait_bursts(input int n);
    int guard = 0;
    while (b_count < n && guard < 20000) begin
      @(posedge user_clk);
      guard++;
    end
    check("bursts_done", b_count, n);
    @(negedge user_clk);
  endtask

  task automatic clear_queues();
    aw_addr_q.delete();
    aw_len_q.delete();
    w_data_q.delete();
    w_last_q.delete();
  endtask

  // Reactive AXI slave: drives readies/response at negedge, then records the
  // handshakes that the following posedge will complete.
  initial begin : slave
    bit          aw_hold, w_hold, b_pend, b_hs_prev;
    logic [31:0] aw_addr_h;
    logic [7:0]  aw_len_h;
    logic [63:0] w_data_h;
    logic        w_last_h;
    int          b_wait;
    aw_hold = 0; w_hold = 0; b_pend = 0; b_hs_prev = 0; b_wait = 0;
    aw_addr_h = '0; aw_len_h = '0; w_data_h = '0; w_last_h = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    forever begin
      @(negedge user_clk);
      if (!user_rst_n) begin
        aw_hold = 0; w_hold = 0; b_pend = 0; b_hs_prev = 0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        continue;
      end
      if (aw_hold) begin
        check("aw_stall_valid", m_axi_awvalid, 1);
        check("aw_stall_addr", m_axi_awaddr, aw_addr_h);
        check("aw_stall_len", m_axi_awlen, aw_len_h);
      end
      if (w_hold) begin
        check("w_stall_valid", m_axi_wvalid, 1);
        check("w_stall_data", m_axi_wdata, w_data_h);
        check("w_stall_last", m_axi_wlast, w_last_h);
      end
      if (m_axi_awvalid || m_axi_wvalid || m_axi_bready)
        check("tready_blocked", s_axis_tready, 0);

      m_axi_awready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
      m_axi_wready  = hold_w ? 1'b0 : (stall ? ($urandom_range(0, 3) == 0) : 1'b1);
      if (b_hs_prev) begin
        m_axi_bvalid = 1'b0;
        b_hs_prev    = 0;
      end
      if (b_pend) begin
        if (b_wait == 0) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (b_count == err_k) ? 2'b10 : 2'b00;
          b_pend       = 0;
        end else begin
          b_wait--;
        end
      end

      aw_hold   = m_axi_awvalid && !m_axi_awready;
      aw_addr_h = m_axi_awaddr;
      aw_len_h  = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_q.push_back(m_axi_awaddr);
        aw_len_q.push_back(m_axi_awlen);
      end
      w_hold   = m_axi_wvalid && !m_axi_wready;
      w_data_h = m_axi_wdata;
      w_last_h = m_axi_wlast;
      if (m_axi_wvalid && m_axi_wready) begin
        w_data_q.push_back(m_axi_wdata);
        w_last_q.push_back(m_axi_wlast);
        if (m_axi_wlast) begin
          b_pend = 1;
          b_wait = stall ? int'($urandom_range(0, 7)) : 0;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_count++;
        b_hs_prev = 1;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int guard;
    int target;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    // Reset values
    user_rst_n = 1'b1;
    #1 user_rst_n = 1'b0;
    #1;
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_wlast", m_axi_wlast, 0);
    check("rst_awaddr", m_axi_awaddr, 32'h0);
    check("rst_awlen", m_axi_awlen, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_burst_cnt", burst_cnt, 0);
    check("rst_tready", s_axis_tready, 0);
    check("awsize", m_axi_awsize, 3);
    check("awburst", m_axi_awburst, 2'b01);
    check("wstrb", m_axi_wstrb, 8'hff);
    repeat (3) @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (2) @(negedge user_clk);

    // Two 32-beat packets, no stalls: four full bursts
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        send_beat(64'(p * 32 + i), i == 31);
        if (p == 0 && i == 15) begin
          check("t1_aw_latency", m_axi_awvalid, 1);
          check("t1_aw_addr0", m_axi_awaddr, 32'h0);
          check("t1_aw_len0", m_axi_awlen, 15);
          check("t1_tready_aw", s_axis_tready, 0);
          @(negedge user_clk);
          check("t1_w_latency", m_axi_wvalid, 1);
          check("t1_w_head", m_axi_wdata, 64'h0);
          check("t1_w_nolast", m_axi_wlast, 0);
        end
      end
    end
    wait_bursts(4);
    check("t1_aw_count", aw_addr_q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check("t1_awaddr", aw_addr_q[j], 64'(j * 'h80));
      check("t1_awlen", aw_len_q[j], 15);
    end
    check("t1_w_count", w_data_q.size(), 64);
    for (int j = 0; j < 64; j++) begin
      check("t1_wdata", w_data_q[j], 64'(j));
      check("t1_wlast", w_last_q[j], (j % 16) == 15);
    end
    check("t1_burst_cnt", burst_cnt, 4);
    clear_queues();

    // Short 5-beat packet; slot wraps back to the region base
    for (int i = 0; i < 5; i++) send_beat(64'(100 + i), i == 4);
    wait_bursts(5);
    check("t2_aw_count", aw_addr_q.size(), 1);
    check("t2_awaddr_wrap", aw_addr_q[0], 32'h0);
    check("t2_awlen", aw_len_q[0], 4);
    check("t2_w_count", w_data_q.size(), 5);
    for (int j = 0; j < 5; j++) begin
      check("t2_wdata", w_data_q[j], 64'(100 + j));
      check("t2_wlast", w_last_q[j], j == 4);
    end
    check("t2_burst_cnt", burst_cnt, 5);
    clear_queues();

    // 1000 beats with random AW/W/B stalls: 62 full bursts + one of 8
    stall = 1'b1;
    for (int i = 0; i < 1000; i++) send_beat(64'h1000 + 64'(i), i == 999);
    wait_bursts(68);
    stall = 1'b0;
    check("t3_aw_count", aw_addr_q.size(), 63);
    for (int j = 0; j < 63; j++) begin
      check("t3_awaddr", aw_addr_q[j], 64'(((5 + j) % 4) * 'h80));
      check("t3_awlen", aw_len_q[j], (j < 62) ? 15 : 7);
    end
    check("t3_w_count", w_data_q.size(), 1000);
    for (int j = 0; j < 1000; j++) begin
      check("t3_wdata", w_data_q[j], 64'h1000 + 64'(j));
      check("t3_wlast", w_last_q[j], ((j % 16) == 15) || (j == 999));
    end
    check("t3_burst_cnt", burst_cnt, 68);
    clear_queues();

    // Error response on the second of three 2-beat bursts
    err_k = 69;
    send_beat(64'h3000, 1'b0);
    send_beat(64'h3001, 1'b1);
    wait_bursts(69);
    check("t4_err_before", wr_err, 0);
    send_beat(64'h3002, 1'b0);
    send_beat(64'h3003, 1'b1);
    wait_bursts(70);
    check("t4_err_set", wr_err, 1);
    check("t4_cnt_after_err", burst_cnt, 70);
    send_beat(64'h3004, 1'b0);
    send_beat(64'h3005, 1'b1);
    wait_bursts(71);
    check("t4_err_sticky", wr_err, 1);
    check("t4_cnt_continue", burst_cnt, 71);
    check("t4_awaddr0", aw_addr_q[0], 32'h000);
    check("t4_awaddr1", aw_addr_q[1], 32'h080);
    check("t4_awaddr2", aw_addr_q[2], 32'h100);
    check("t4_awlen", aw_len_q[2], 1);
    check("t4_wdata5", w_data_q[5], 64'h3005);
    err_k = -1;
    clear_queues();

    // Reset while a burst is parked in the W phase
    hold_w = 1'b1;
    for (int i = 0; i < 16; i++) send_beat(64'h4000 + 64'(i), 1'b0);
    guard = 0;
    while (!m_axi_wvalid && guard < 200) begin
      @(negedge user_clk);
      guard++;
    end
    check("t5_in_w", m_axi_wvalid, 1);
    check("t5_slot_before", m_axi_awaddr, 32'h180);
    #2 user_rst_n = 1'b0;
    #1;
    check("t5_rst_awvalid", m_axi_awvalid, 0);
    check("t5_rst_wvalid", m_axi_wvalid, 0);
    check("t5_rst_bready", m_axi_bready, 0);
    check("t5_rst_wlast", m_axi_wlast, 0);
    check("t5_rst_awaddr", m_axi_awaddr, 32'h0);
    check("t5_rst_burst_cnt", burst_cnt, 0);
    check("t5_rst_wr_err", wr_err, 0);
    check("t5_rst_tready", s_axis_tready, 0);
    hold_w = 1'b0;
    #57 user_rst_n = 1'b1;
    clear_queues();
    repeat (2) @(negedge user_clk);
    target = b_count + 1;
    for (int i = 0; i < 16; i++) send_beat(64'h5000 + 64'(i), 1'b0);
    wait_bursts(target);
    check("t5_aw_count", aw_addr_q.size(), 1);
    check("t5_awaddr_base", aw_addr_q[0], 32'h0);
    check("t5_awlen", aw_len_q[0], 15);
    check("t5_w_count", w_data_q.size(), 16);
    for (int j = 0; j < 16; j++) check("t5_wdata", w_data_q[j], 64'h5000 + 64'(j));
    check("t5_burst_cnt", burst_cnt, 1);
    check("t5_wr_err", wr_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
